// File: rtl/inst_mem_pkg.sv
// Shared widths and FSM encoding for the instruction memory and the
// memory-side port of the instruction cache.
package inst_mem_pkg;

    localparam int BLOCK_BITS      = 128;
    localparam int BLOCK_ADDR_BITS = 6;
    localparam int WORD_ADDR_BITS  = 8;
    localparam int WORD_BITS       = 32;
    localparam int NUM_BLOCKS      = 64;
    localparam int CNT_BITS        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/inst_mem_array.sv
// 64 x 128-bit block storage: synchronous 32-bit word write and
// asynchronous whole-block read.
module inst_mem_array
    import inst_mem_pkg::*;
(
    input  logic                       clock,
    input  logic                       we,
    input  logic [WORD_ADDR_BITS-1:0]  waddr,
    input  logic [WORD_BITS-1:0]       wdata,
    input  logic [BLOCK_ADDR_BITS-1:0] raddr,
    output logic [BLOCK_BITS-1:0]      rdata
);

    logic [BLOCK_BITS-1:0] mem [NUM_BLOCKS];

    // NOTE: storage arrays are never reset; clearing them would block RAM inference.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr[7:2]][{waddr[1:0], 5'b0} +: WORD_BITS] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_memory.sv
// Backing instruction memory: fixed-latency 128-bit block reads stalled via
// mem_busywait, plus a word-wide program-load port.
module inst_memory
    import inst_mem_pkg::*;
#(
    parameter int READ_CYCLES = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mem_read,
    input  logic [BLOCK_ADDR_BITS-1:0] mem_address,
    output logic [BLOCK_BITS-1:0]      mem_readdata,
    output logic                       mem_busywait,
    input  logic                       prog_we,
    input  logic [WORD_ADDR_BITS-1:0]  prog_addr,
    input  logic [WORD_BITS-1:0]       prog_wdata
);

    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(READ_CYCLES - 1);

    state_t                     state, state_nxt;
    logic [CNT_BITS-1:0]        cnt, cnt_nxt;
    logic [BLOCK_ADDR_BITS-1:0] addr_q, addr_nxt;
    logic                       capture;
    logic [BLOCK_BITS-1:0]      block_data;

    inst_mem_array u_array (
        .clock (clock),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (addr_q),
        .rdata (block_data)
    );

    // Combinational so the stall is visible in the same cycle the request rises.
    assign mem_busywait = mem_read && (state != DONE);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    addr_nxt  = mem_address;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!mem_read) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The array read is sampled before any same-edge program write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            mem_readdata <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            if (capture) begin
                mem_readdata <= block_data;
            end
        end
    end

endmodule

// File: tb/tb_inst_memory.sv
// Scoreboard bench for inst_memory: reads push expected blocks, a monitor
// pops and compares data and stall length whenever a read completes.
module tb_inst_memory;

    localparam int RC = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic         prog_we;
    logic [7:0]   prog_addr;
    logic [31:0]  prog_wdata;

    logic         r1_mem_read;
    logic [5:0]   r1_mem_address;
    logic [127:0] r1_mem_readdata;
    logic         r1_mem_busywait;
    logic         r1_prog_we;
    logic [7:0]   r1_prog_addr;
    logic [31:0]  r1_prog_wdata;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] BLK0    = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BLK63   = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] BLK1    = 128'h40000004_30000003_20000002_10000001;
    localparam logic [127:0] BLK5    = 128'h55550003_55550002_55550001_55550000;
    localparam logic [127:0] BLK9    = 128'h99990003_99990002_99990001_99990000;
    localparam logic [127:0] BLK5_DB = 128'h55550003_55550002_55550001_DEADBEEF;
    localparam logic [127:0] BLK5_CF = 128'h55550003_55550002_55550001_CAFEF00D;
    localparam logic [127:0] R1_BLK2 = 128'hB0B00003_B0B00002_B0B00001_B0B00000;

    inst_memory #(.READ_CYCLES(RC)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata)
    );

    inst_memory #(.READ_CYCLES(1)) dut_rc1 (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (r1_mem_read),
        .mem_address  (r1_mem_address),
        .mem_readdata (r1_mem_readdata),
        .mem_busywait (r1_mem_busywait),
        .prog_we      (r1_prog_we),
        .prog_addr    (r1_prog_addr),
        .prog_wdata   (r1_prog_wdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: a completed read is mem_read high with mem_busywait low.
    always @(negedge clock) begin
        if (reset || !mem_read) begin
            busy_cnt = 0;
        end else if (mem_busywait) begin
            busy_cnt++;
        end else begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got data %h with no read outstanding", mem_readdata);
            end else begin
                check("read_data", mem_readdata, exp_q.pop_front());
                check("read_latency", 128'(busy_cnt), 128'(RC + 1));
            end
            busy_cnt = 0;
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic prog_write(input logic [7:0] addr, input logic [31:0] data);
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_wdata = data;
        @(posedge clock);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic prog_block(input logic [5:0] blk, input logic [127:0] data);
        for (int w = 0; w < 4; w++) begin
            prog_write({blk, 2'(w)}, data[w*32 +: 32]);
        end
    endtask

    task automatic start_read(input logic [5:0] addr, input logic [127:0] expected);
        mem_read    = 1'b1;
        mem_address = addr;
        exp_q.push_back(expected);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!mem_busywait) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got busywait still high after 40 cycles expected low");
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        mem_read       = 1'b0;
        mem_address    = '0;
        prog_we        = 1'b0;
        prog_addr      = '0;
        prog_wdata     = '0;
        r1_mem_read    = 1'b0;
        r1_mem_address = '0;
        r1_prog_we     = 1'b0;
        r1_prog_addr   = '0;
        r1_prog_wdata  = '0;
        repeat (2) @(posedge clock);
        #1;

        // Program writes are accepted while reset is held.
        prog_block(6'd0, BLK0);
        mem_read    = 1'b1;
        mem_address = 6'd0;
        #2;
        check("rst_busywait", 128'(mem_busywait), 128'(1));
        check("rst_readdata", mem_readdata, '0);
        exp_q.push_back(BLK0);
        reset = 1'b0;
        wait_done();
        mem_read = 1'b0;

        prog_block(6'd63, BLK63);
        prog_block(6'd1, BLK1);
        prog_block(6'd5, BLK5);
        prog_block(6'd9, BLK9);

        // Back-to-back reads; first result held until second completes.
        start_read(6'd63, BLK63);
        wait_done();
        start_read(6'd1, BLK1);
        @(posedge clock);
        #1;
        check("hold_prev_block", mem_readdata, BLK63);
        wait_done();
        mem_read = 1'b0;

        // Address change after the request edge is ignored.
        start_read(6'd5, BLK5);
        @(posedge clock);
        #1;
        mem_address = 6'd9;
        wait_done();
        mem_read = 1'b0;

        // Abort after two BUSY edges.
        @(posedge clock);
        #1;
        mem_read    = 1'b1;
        mem_address = 6'd9;
        repeat (3) @(posedge clock);
        #1;
        mem_read = 1'b0;
        #1;
        check("abort_busywait", 128'(mem_busywait), 128'(0));
        repeat (2) @(posedge clock);
        #1;
        check("abort_hold_data", mem_readdata, BLK5);
        start_read(6'd9, BLK9);
        wait_done();
        mem_read = 1'b0;

        // Write during BUSY before the capture edge is visible.
        start_read(6'd5, BLK5_DB);
        @(posedge clock);
        #1;
        prog_write(8'd20, 32'hDEADBEEF);
        wait_done();
        mem_read = 1'b0;

        // Write on the capture edge is not visible in that capture.
        @(posedge clock);
        #1;
        start_read(6'd5, BLK5_DB);
        repeat (5) @(posedge clock);
        #1;
        prog_write(8'd20, 32'hCAFEF00D);
        wait_done();
        mem_read = 1'b0;
        start_read(6'd5, BLK5_CF);
        wait_done();
        mem_read = 1'b0;

        // READ_CYCLES = 1 instance: DONE at the second edge.
        for (int w = 0; w < 4; w++) begin
            r1_prog_we    = 1'b1;
            r1_prog_addr  = 8'(8 + w);
            r1_prog_wdata = 32'hB0B00000 + 32'(w);
            @(posedge clock);
            #1;
        end
        r1_prog_we     = 1'b0;
        r1_mem_read    = 1'b1;
        r1_mem_address = 6'd2;
        @(negedge clock);
        check("rc1_busy_e0", 128'(r1_mem_busywait), 128'(1));
        @(negedge clock);
        check("rc1_busy_e1", 128'(r1_mem_busywait), 128'(1));
        @(negedge clock);
        check("rc1_ready_e2", 128'(r1_mem_busywait), 128'(0));
        check("rc1_data", r1_mem_readdata, R1_BLK2);
        @(posedge clock);
        #1;
        r1_mem_read = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_memory.md
# inst_memory

Backing instruction memory directly downstream of the instruction cache. Holds 64 blocks of 16 bytes (1 KiB) and serves whole 128-bit blocks to the cache's miss handler. Each block read takes a fixed, parameterised number of clock cycles and is stalled with a busywait handshake. A word-wide programming port loads the program image before or between fetches.

## Interface
- READ_CYCLES, 5, number of clock edges spent in BUSY per block read; legal range 1..15.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all control state.
- mem_read  in  1  block read request from the cache; held high until the cache samples mem_busywait low.
- mem_address  in  6  block index (byte address bits [9:4]).
- mem_readdata  out  128  returned block; byte k of the block is bits [8k+7:8k].
- mem_busywait  out  1  stall to the cache; combinational.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  8  word address (byte address bits [9:2]).
- prog_wdata  in  32  word to store, little-endian within the word.

## Operation
- States: IDLE, BUSY, DONE.
- mem_busywait = mem_read AND (state != DONE). It rises in the same cycle mem_read rises, so the cache never samples a false "ready" on the edge after it issues a request.
- IDLE:
  - If mem_read is high at an edge: latch mem_address into addr_q, load cnt = READ_CYCLES-1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If mem_read is low at an edge (abort): go to IDLE; mem_readdata is unchanged.
  - Else if cnt == 0: mem_readdata <= array[addr_q], go to DONE.
  - Else: cnt <= cnt-1.
- DONE: go to IDLE unconditionally at the next edge. This is the edge on which the cache samples the data and drops mem_read.
- mem_address changes while in BUSY or DONE are ignored; addr_q governs.
- mem_readdata is registered and holds the last completed block until the next completion.
- Programming port:
  - prog_we at an edge writes prog_wdata to word prog_addr[1:0] of block prog_addr[7:2].
  - Writes are accepted in any state.
  - A write on the same edge as the BUSY->DONE capture is not visible in that capture (old contents returned). Earlier writes to addr_q are visible.
- Reset:
  - state = IDLE, cnt = 0, addr_q = 0, mem_readdata = 0.
  - mem_busywait therefore equals mem_read.
  - Array contents are not cleared.
  - Reset in the middle of a read abandons it; no data update.

## Timing
- Edge E0: cache raises mem_read; mem_busywait goes high in the same cycle.
- E1: IDLE->BUSY.
- E1+READ_CYCLES: BUSY->DONE, mem_readdata valid, mem_busywait low.
- E1+READ_CYCLES+1: cache consumes data; DONE->IDLE.
- Total from E1 to DONE entry: READ_CYCLES edges (5 by default).
- Back-to-back: if mem_read is high again at the first edge after returning to IDLE, the next read starts with no bubble beyond that IDLE edge.
- READ_CYCLES = 1: DONE is reached at E2.

## Structure
- Shared package inst_mem_pkg:
  - BLOCK_BITS = 128, BLOCK_ADDR_BITS = 6, WORD_ADDR_BITS = 8, NUM_BLOCKS = 64.
  - State encoding (IDLE/BUSY/DONE).
  - Shared with the instruction cache for its memory-side port widths.
- Sub-module inst_mem_array: 64×128 storage with a synchronous 32-bit word write (byte-lane placement by prog_addr[1:0]) and an asynchronous 128-bit block read. The control FSM, counter and output register live in inst_memory.

## Test plan
- Reset with mem_read = 1 -> mem_busywait = 1, mem_readdata = 0, state IDLE. Release reset -> read proceeds normally.
- Program block 0 words 0x11111111, 0x22222222, 0x33333333, 0x44444444. Read mem_address = 0 with READ_CYCLES = 5 -> mem_busywait high for 6 sampled edges, then mem_readdata = 0x44444444_33333333_22222222_11111111 with mem_busywait low exactly one cycle.
- Read block 63 (prog_addr 252..255 = 0xA0..0xA3), then immediately block 1 -> second block returned after the same latency; first result held in mem_readdata until the second DONE.
- Start a read of block 5; change mem_address to 9 on the edge after the request -> block 5 returned.
- Start a read, drop mem_read after 2 BUSY edges -> IDLE next edge, mem_readdata unchanged, mem_busywait low.
- Write word 0xDEADBEEF to prog_addr 20 (block 5, word 0) during BUSY before the final edge -> captured. Write it on the capture edge instead -> old word returned.
